// File: rtl/flash_read_responder_if.sv
// Avalon-MM flash read bus between flash_read_responder (master) and the
// flash controller (slave). Word addressed; byteenable is always full-word.
interface flash_read_responder_if #(
  parameter int ADDR_W = 23
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_read_responder.sv
// flash_read_responder: services one-word read requests from the flash reader
// FSM, runs a single outstanding Avalon-MM read, returns the word on data_out
// with a one-cycle read_data_flag pulse and steps the sample address pointer
// (forward/reverse, bound handling, restart).
// Build option: define FLASH_LOOP_EN to wrap the pointer at the song bounds
// (end_flag tied low); otherwise the pointer stops at a bound and end_flag
// blocks further requests until restart or reset.
module flash_read_responder #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic                  clk50M,
  input  logic                  reset,
  input  logic                  read_addr_flag,
  input  logic                  direction,
  input  logic                  restart,
  output logic                  read_data_flag,
  output logic [31:0]           data_out,
  output logic [ADDR_W-1:0]     cur_addr,
  output logic                  end_flag,
  flash_read_responder_if.master flash_mem
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_VALID,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              pending_restart;
  logic              mem_read;
  logic              req_accept;
  logic              reload_now;

  // Pointer is at the bound it would step past in the given direction.
  function automatic logic at_bound(input logic [ADDR_W-1:0] a, input logic dir);
    return dir ? (a == START_ADDR) : (a == END_ADDR);
  endfunction

  // Restart target: the first sample of the chosen play direction.
  function automatic logic [ADDR_W-1:0] reload_addr(input logic dir);
    return dir ? END_ADDR : START_ADDR;
  endfunction

  // One step of the pointer, including the bound rule.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic dir);
    if (at_bound(a, dir)) begin
`ifdef FLASH_LOOP_EN
      return dir ? END_ADDR : START_ADDR;
`else
      return a;
`endif
    end
    return dir ? (a - ADDR_W'(1)) : (a + ADDR_W'(1));
  endfunction

  assign req_accept = (state == IDLE) && read_addr_flag && !end_flag;
  // In DONE a restart seen during the transaction (or right now) replaces the step.
  assign reload_now = pending_restart || restart;

  // FSM state register.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_nxt      = state;
    mem_read       = 1'b0;
    read_data_flag = 1'b0;
    case (state)
      IDLE: begin
        if (req_accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_read = 1'b1;
        // Data may already be valid in the acceptance cycle.
        if (!flash_mem.flash_mem_waitrequest)
          state_nxt = flash_mem.flash_mem_readdatavalid ? DONE : WAIT_VALID;
      end
      WAIT_VALID: begin
        if (flash_mem.flash_mem_readdatavalid) state_nxt = DONE;
      end
      DONE: begin
        read_data_flag = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer, latched bus address, returned data and deferred restart.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      cur_addr        <= START_ADDR;
      addr_q          <= START_ADDR;
      data_out        <= 32'h0;
      pending_restart <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (restart) cur_addr <= reload_addr(direction);
          if (req_accept) addr_q <= restart ? reload_addr(direction) : cur_addr;
        end
        ISSUE: begin
          if (restart) pending_restart <= 1'b1;
          if (!flash_mem.flash_mem_waitrequest && flash_mem.flash_mem_readdatavalid)
            data_out <= flash_mem.flash_mem_readdata;
        end
        WAIT_VALID: begin
          if (restart) pending_restart <= 1'b1;
          if (flash_mem.flash_mem_readdatavalid)
            data_out <= flash_mem.flash_mem_readdata;
        end
        DONE: begin
          pending_restart <= 1'b0;
          if (reload_now) cur_addr <= reload_addr(direction);
          else            cur_addr <= step_addr(cur_addr, direction);
        end
        default: ;
      endcase
    end
  end

`ifdef FLASH_LOOP_EN
  assign end_flag = 1'b0;
`else
  // Sticky end-of-song flag: set when a step hits a bound, cleared by restart.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      end_flag <= 1'b0;
    end else if (state == IDLE && restart) begin
      end_flag <= 1'b0;
    end else if (state == DONE) begin
      if (reload_now)                          end_flag <= 1'b0;
      else if (at_bound(cur_addr, direction))  end_flag <= 1'b1;
    end
  end
`endif

  assign flash_mem.flash_mem_read       = mem_read;
  assign flash_mem.flash_mem_address    = addr_q;
  assign flash_mem.flash_mem_byteenable = 4'b1111;

endmodule

// File: doc/flash_read_responder.md
Name: flash_read_responder

Overview:
- Services single-word read requests from the flash reader FSM and drives the Avalon-MM flash read master.
- Owns the sample address pointer: forward/reverse stepping, wrap at the song bounds, restart.
- Returns each 32-bit word on data_out and signals completion with a one-cycle read_data_flag pulse, which the reader uses to leave its READ_DATA state.

Parameters:
- ADDR_W, 23, flash word-address width.
- START_ADDR, 23'h000000, first word of the audio region.
- END_ADDR, 23'h07FFFF, last word of the audio region, inclusive.

Ports:
- clk50M  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- read_addr_flag  in  1  read request from the reader FSM; sampled only in IDLE
- direction  in  1  0 = forward (increment), 1 = reverse (decrement)
- restart  in  1  pulse: reload the pointer to the start of the play direction
- read_data_flag  out  1  one-cycle pulse: data_out valid, transaction complete
- data_out  out  32  last word returned by flash
- cur_addr  out  ADDR_W  current pointer (next address to be read)
- end_flag  out  1  pointer reached a bound and stopped (only without LOOP_EN)
- flash_mem_read  out  1  Avalon read strobe
- flash_mem_address  out  ADDR_W  Avalon word address
- flash_mem_byteenable  out  4  constant 4'b1111
- flash_mem_waitrequest  in  1  Avalon waitrequest
- flash_mem_readdata  in  32  Avalon read data
- flash_mem_readdatavalid  in  1  Avalon read data valid

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE, cur_addr = START_ADDR.
  - data_out = 0, read_data_flag = 0, flash_mem_read = 0, end_flag = 0.
  - pending_restart = 0.
- Release of reset is clean. No request is accepted until the first clock edge in IDLE.
- States:
  - IDLE:
    - If read_addr_flag && !end_flag, go to ISSUE. Latch flash_mem_address = cur_addr.
    - If end_flag is set, the request is ignored and no pulse is produced.
  - ISSUE:
    - flash_mem_read = 1 and address held stable.
    - Stay while waitrequest = 1. When waitrequest = 0, go to WAIT_VALID and drop read the next cycle.
  - WAIT_VALID:
    - On readdatavalid, register data_out <= readdata and go to DONE.
    - readdatavalid may arrive in the same cycle the read is accepted; it is registered correctly.
  - DONE:
    - read_data_flag = 1 for exactly this cycle.
    - Pointer update (below) takes effect. Return to IDLE.
- Minimum latency: request seen at cycle 0 gives read_data_flag at cycle 3 (waitrequest = 0, readdatavalid one cycle after acceptance). Each waitrequest or readdatavalid stall cycle adds one.
- read_addr_flag asserted outside IDLE is ignored. One outstanding read at a time, no pipelining.
- Pointer update in DONE, forward:
  - cur_addr == END_ADDR: apply the bound rule.
  - Otherwise cur_addr + 1.
- Pointer update in DONE, reverse:
  - cur_addr == START_ADDR: apply the bound rule.
  - Otherwise cur_addr - 1.
- All pointer arithmetic is ADDR_W bits unsigned. The pointer never leaves [START_ADDR, END_ADDR].
- direction is sampled in DONE. A change mid-transaction affects only the next step.
- restart handling:
  - In IDLE: cur_addr <= (direction ? END_ADDR : START_ADDR) next cycle, and end_flag is cleared.
  - Outside IDLE: pending_restart is set. In DONE the reload replaces the step and pending_restart is cleared.
  - restart coincident with read_addr_flag in IDLE: the reload applies and the transaction starts at the reloaded address.
- Reset mid-transaction: abort immediately and drop flash_mem_read. Any later readdatavalid is ignored while in IDLE.
- flash_mem_byteenable is tied to 4'b1111.

Optional Feature:
- Macro: FLASH_LOOP_EN.
- Defined:
  - The bound rule wraps. Forward at END_ADDR goes to START_ADDR; reverse at START_ADDR goes to END_ADDR.
  - end_flag is tied to 0.
- Undefined:
  - The bound rule holds the pointer at the bound and sets end_flag in DONE.
  - end_flag stays set until restart or reset. While it is set, requests are ignored.

Test Plan:
- Forward basic: reset, direction = 0, waitrequest = 0, readdata = 32'hDEADBEEF valid one cycle after read -> read_data_flag pulses 3 cycles after read_addr_flag, data_out = 32'hDEADBEEF, cur_addr = 1.
- Stalls: waitrequest held 4 cycles, readdatavalid delayed 2 cycles -> address stable throughout, a single one-cycle read_data_flag, flag latency = 3 + 6 cycles.
- Bound: set cur_addr to END_ADDR via reverse restart, then direction = 0 and one read:
  - FLASH_LOOP_EN defined: cur_addr = 0.
  - Undefined: cur_addr = 23'h07FFFF, end_flag = 1, and the next read_addr_flag produces no flash_mem_read.
- Reverse wrap: direction = 1 at cur_addr = 0 with FLASH_LOOP_EN -> after DONE, cur_addr = 23'h07FFFF.
- Restart mid-transaction: cur_addr = 23'h000010, restart pulsed during ISSUE -> transaction reads 0x10, then cur_addr = 0 rather than 0x11.
- Reset mid-transaction: reset asserted in WAIT_VALID, readdatavalid arrives afterwards -> no read_data_flag, data_out = 0, cur_addr = START_ADDR.
